// File: rtl/up_sample_pkg.sv
// Shared types and defaults for the up_sample pipeline stage controllers.
package up_sample_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CTRL_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stage_state_e;

    // Buffer ctrl vars: [0]=0, [1]=y, [2]=x.
    typedef logic [2:0][CTRL_W_DEF-1:0] ctrl_vars_t;

endpackage

// File: rtl/up_sample_domain_iter.sv
// Row-major 2-D wrapping counter over {[0,EXT_X-1],[0,EXT_Y-1]} with clear, enable and last flag.
module up_sample_domain_iter
    import up_sample_pkg::*;
#(
    parameter int EXT_X  = 128,
    parameter int EXT_Y  = 128,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [CTRL_W-1:0] x,
    output logic [CTRL_W-1:0] y,
    output logic              last
);

    localparam logic [CTRL_W-1:0] X_MAX = CTRL_W'(EXT_X - 1);
    localparam logic [CTRL_W-1:0] Y_MAX = CTRL_W'(EXT_Y - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + CTRL_W'(1);
            end else begin
                x <= x + CTRL_W'(1);
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/nn_upsample_stage_ctrl.sv
// Sequencer for op_hcompute_nearest_neighbor_stencil: reads hw_input_stencil at each output
// point and writes the pixel to nearest_neighbor_stencil one cycle later. Macro NN_UPSAMPLE_STAGE_PERF_EN adds stall_cycles.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | one read per unstalled cycle, previous read written
// ST_DRAIN | last captured pixel waits for an unstalled cycle to be written
// ST_DONE  | one-cycle done pulse
module nn_upsample_stage_ctrl
    import up_sample_pkg::*;
#(
    parameter int OUT_W  = 128,
    parameter int OUT_H  = 128,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic                   nn_read_ren,
    output logic [2:0][CTRL_W-1:0] nn_read_ctrl_vars,
    input  logic [DATA_W-1:0]      nn_read_data,
    output logic                   nn_write_wen,
    output logic [2:0][CTRL_W-1:0] nn_write_ctrl_vars,
    output logic [DATA_W-1:0]      nn_write_data
`ifdef NN_UPSAMPLE_STAGE_PERF_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    stage_state_e      state;
    logic [CTRL_W-1:0] x, y;
    logic              last;
    logic              run;
    logic              it_en;
    logic              it_clr;
    logic              wr_valid;
    logic [CTRL_W-1:0] wr_x, wr_y;
    logic [DATA_W-1:0] wr_data;

    assign run    = (state == ST_RUN);
    assign it_en  = run && !stall && !flush;
    assign it_clr = flush || ((state == ST_IDLE) && start);

    up_sample_domain_iter #(
        .EXT_X  (OUT_W),
        .EXT_Y  (OUT_H),
        .CTRL_W (CTRL_W)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (it_clr),
        .en    (it_en),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_valid <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
        end else if (flush) begin
            state    <= ST_IDLE;
            wr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_valid <= 1'b0;
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!stall) begin
                        wr_valid <= 1'b1;
                        wr_x     <= x;
                        wr_y     <= y;
                        wr_data  <= nn_read_data;
                        if (last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        wr_valid <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wr_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    wr_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy               = run || (state == ST_DRAIN);
    assign done               = (state == ST_DONE);
    assign nn_read_ren        = it_en;
    assign nn_read_ctrl_vars  = run ? {x, y, {CTRL_W{1'b0}}} : '0;
    assign nn_write_wen       = wr_valid && !stall && !flush;
    assign nn_write_ctrl_vars = {wr_x, wr_y, {CTRL_W{1'b0}}};
    assign nn_write_data      = wr_data;

`ifdef NN_UPSAMPLE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state == ST_IDLE) && start && !flush) begin
            stall_cycles <= '0;
        end else if (busy && stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_upsample_stage_ctrl.sv
// Self-checking bench for nn_upsample_stage_ctrl: directed steps with random stall against a
// coordinate-indexed downstream buffer model.
module tb_nn_upsample_stage_ctrl;

    localparam int W      = 128;
    localparam int H      = 128;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int NPTS   = W * H;
    localparam int BUDGET = 40000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               start = 1'b0;
    logic               stall = 1'b0;
    logic               busy;
    logic               done;
    logic               nn_read_ren;
    logic [2:0][CW-1:0] nn_read_ctrl_vars;
    logic [DW-1:0]      nn_read_data;
    logic               nn_write_wen;
    logic [2:0][CW-1:0] nn_write_ctrl_vars;
    logic [DW-1:0]      nn_write_data;
`ifdef NN_UPSAMPLE_STAGE_PERF_EN
    logic [31:0]        stall_cycles;
`endif

    nn_upsample_stage_ctrl #(
        .OUT_W  (W),
        .OUT_H  (H),
        .DATA_W (DW),
        .CTRL_W (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .start              (start),
        .stall              (stall),
        .busy               (busy),
        .done               (done),
        .nn_read_ren        (nn_read_ren),
        .nn_read_ctrl_vars  (nn_read_ctrl_vars),
        .nn_read_data       (nn_read_data),
        .nn_write_wen       (nn_write_wen),
        .nn_write_ctrl_vars (nn_write_ctrl_vars),
        .nn_write_data      (nn_write_data)
`ifdef NN_UPSAMPLE_STAGE_PERF_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Upstream buffer: value(row,col)=row*64+col, addressed with the floor(/2) it applies internally.
    logic [CW-1:0] rd_x, rd_y;
    assign rd_y = nn_read_ctrl_vars[1];
    assign rd_x = nn_read_ctrl_vars[2];
    assign nn_read_data = DW'((int'(rd_y) / 2) * 64 + int'(rd_x) / 2);

    int            n_checks = 0;
    int            n_err    = 0;
    int            wr_cnt [NPTS];
    logic [DW-1:0] wr_val [NPTS];
    int            n_writes, n_reads, done_cnt, wen_stall, ren_stall, busy_stall, ctrl0_bad, oob;
    int            start_pulses;
    int            lat;
    int            first_x, first_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: observe mid-cycle at the falling edge, return just after the rising edge.
    task automatic cyc();
        int idx;
        @(negedge clk);
        if (nn_write_wen) begin
            n_writes++;
            if (nn_write_ctrl_vars[0] != '0) ctrl0_bad++;
            if (int'(nn_write_ctrl_vars[1]) < H && int'(nn_write_ctrl_vars[2]) < W) begin
                idx = int'(nn_write_ctrl_vars[1]) * W + int'(nn_write_ctrl_vars[2]);
                wr_cnt[idx]++;
                wr_val[idx] = nn_write_data;
            end else begin
                oob++;
            end
        end
        if (nn_read_ren) begin
            n_reads++;
            if (nn_read_ctrl_vars[0] != '0) ctrl0_bad++;
        end
        if (nn_write_wen && stall) wen_stall++;
        if (nn_read_ren && stall) ren_stall++;
        if (busy && stall) busy_stall++;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NPTS; i++) begin
            wr_cnt[i] = 0;
            wr_val[i] = '0;
        end
        n_writes = 0; n_reads = 0; done_cnt = 0; wen_stall = 0; ren_stall = 0;
        busy_stall = 0; ctrl0_bad = 0; oob = 0; start_pulses = 0;
    endtask

    // mode 0: no stall; 1: ~30% random stall; 2: 37 stall cycles plus a start pulse at (0,50).
    task automatic run_frame(input int mode);
        clear_model();
        start = 1'b1;
        cyc();
        start = 1'b0;
        first_x = int'(rd_x);
        first_y = int'(rd_y);
        lat = 0;
        while (done_cnt == 0 && lat < BUDGET) begin
            lat++;
            case (mode)
                1:       stall = ($urandom_range(99) < 30);
                2:       stall = (lat >= 100 && lat < 137);
                default: stall = 1'b0;
            endcase
            start = (mode == 2) && busy && (rd_y == CW'(50)) && (rd_x == '0);
            if (start) start_pulses++;
            cyc();
        end
        stall = 1'b0;
        start = 1'b0;
        repeat (4) cyc();
        check("frame_done_seen", 64'(done_cnt > 0), 64'd1);
    endtask

    function automatic int frame_errors();
        int bad = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (wr_cnt[yy*W+xx] != 1 || wr_val[yy*W+xx] != DW'((yy / 2) * 64 + xx / 2))
                    bad++;
        return bad;
    endfunction

    initial begin
        int k;

        // Reset
        repeat (3) cyc();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ren", 64'(nn_read_ren), 64'd0);
        check("rst_wen", 64'(nn_write_wen), 64'd0);
        check("rst_rd_ctrl", 64'(nn_read_ctrl_vars), 64'd0);
        check("rst_wr_ctrl", 64'(nn_write_ctrl_vars), 64'd0);
        check("rst_wr_data", 64'(nn_write_data), 64'd0);
        rst_n = 1'b1;
        repeat (2) cyc();
        check("idle_busy", 64'(busy), 64'd0);

        // Frame 1: unstalled
        run_frame(0);
        check("f1_latency", 64'(lat), 64'(NPTS + 2));
        check("f1_first_x", 64'(first_x), 64'd0);
        check("f1_first_y", 64'(first_y), 64'd0);
        check("f1_bad_points", 64'(frame_errors()), 64'd0);
        check("f1_writes", 64'(n_writes), 64'(NPTS));
        check("f1_reads", 64'(n_reads), 64'(NPTS));
        check("f1_done_pulses", 64'(done_cnt), 64'd1);
        check("f1_pix_5_7", 64'(wr_val[5*W+7]), 64'd131);
        check("f1_ctrl0", 64'(ctrl0_bad + oob), 64'd0);
        check("f1_busy_after", 64'(busy), 64'd0);

        // Frame 2: random stall
        run_frame(1);
        check("f2_bad_points", 64'(frame_errors()), 64'd0);
        check("f2_writes", 64'(n_writes), 64'(NPTS));
        check("f2_reads", 64'(n_reads), 64'(NPTS));
        check("f2_wen_in_stall", 64'(wen_stall), 64'd0);
        check("f2_ren_in_stall", 64'(ren_stall), 64'd0);
        check("f2_done_pulses", 64'(done_cnt), 64'd1);
        check("f2_stalls_seen", 64'(busy_stall > 0), 64'd1);
        check("f2_latency", 64'(lat), 64'(NPTS + 2 + busy_stall));

        // Flush at RUN (x=10,y=3)
        clear_model();
        start = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
        while (!(rd_y == CW'(3) && rd_x == CW'(10)) && k < 2000) begin
            cyc();
            k++;
        end
        check("fl_reached", 64'(k < 2000), 64'd1);
        flush = 1'b1;
        #1;
        check("fl_ren_same_cycle", 64'(nn_read_ren), 64'd0);
        check("fl_wen_same_cycle", 64'(nn_write_wen), 64'd0);
        cyc();
        flush = 1'b0;
        check("fl_busy_next", 64'(busy), 64'd0);
        check("fl_rd_ctrl_next", 64'(nn_read_ctrl_vars), 64'd0);
        repeat (4) cyc();
        check("fl_no_done", 64'(done_cnt), 64'd0);
        check("fl_no_write_after", 64'(nn_write_wen), 64'd0);

        // Frame 3: after flush, fixed 37 stalls and an ignored start while busy
        run_frame(2);
        check("f3_first_x", 64'(first_x), 64'd0);
        check("f3_first_y", 64'(first_y), 64'd0);
        check("f3_bad_points", 64'(frame_errors()), 64'd0);
        check("f3_writes", 64'(n_writes), 64'(NPTS));
        check("f3_start_pulsed", 64'(start_pulses), 64'd1);
        check("f3_done_pulses", 64'(done_cnt), 64'd1);
        check("f3_busy_stalls", 64'(busy_stall), 64'd37);
        check("f3_latency", 64'(lat), 64'(NPTS + 2 + 37));
`ifdef NN_UPSAMPLE_STAGE_PERF_EN
        check("f3_stall_cycles", 64'(stall_cycles), 64'd37);
`endif

        // Asynchronous reset mid-frame
        clear_model();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (200) cyc();
        check("ar_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_ren", 64'(nn_read_ren), 64'd0);
        check("ar_wen", 64'(nn_write_wen), 64'd0);
        check("ar_rd_ctrl", 64'(nn_read_ctrl_vars), 64'd0);
        check("ar_wr_ctrl", 64'(nn_write_ctrl_vars), 64'd0);
        check("ar_wr_data", 64'(nn_write_data), 64'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        n_reads = 0;
        repeat (6) cyc();
        check("ar_needs_start", 64'(busy), 64'd0);
        check("ar_no_reads", 64'(n_reads), 64'd0);
        check("ar_no_done", 64'(done_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nn_upsample_stage_ctrl.md
Name: nn_upsample_stage_ctrl

Overview:
- Sequencer for the op_hcompute_nearest_neighbor_stencil stage of the up_sample pipeline.
- Sits between the hw_input_stencil buffer and the nearest_neighbor_stencil buffer.
- Walks the output iteration domain {[0,OUT_W-1],[0,OUT_H-1]} in row-major order. For each point it drives read enable and ctrl vars into the upstream buffer, which applies floor(/2) internally. It then writes the returned pixel, one cycle later, to the downstream buffer at the same coordinates.
- Start/done handshake; global stall and flush supported.

Parameters:
- OUT_W, 128, output columns (x extent).
- OUT_H, 128, output rows (y extent).
- DATA_W, 16, pixel width.
- CTRL_W, 16, ctrl-var width; OUT_W and OUT_H must each be ≤ 2^CTRL_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort to IDLE.
- start  in  1  begin one frame; sampled in IDLE only.
- stall  in  1  freeze counters and pipeline.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- nn_read_ren  out  1  read enable to upstream buffer.
- nn_read_ctrl_vars  out  3xCTRL_W  [0]=0, [1]=y, [2]=x.
- nn_read_data  in  1xDATA_W  combinational read data, valid in the same cycle as ren.
- nn_write_wen  out  1  write enable to downstream buffer.
- nn_write_ctrl_vars  out  3xCTRL_W  [0]=0, [1]=y, [2]=x of the write.
- nn_write_data  out  1xDATA_W  pixel to write.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; x=y=0.
  - Write-stage valid=0; write ctrl/data registers=0.
  - All outputs 0.
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 moves to RUN next cycle with x=y=0. start in any other state is ignored.
  - RUN: each cycle with stall=0:
    - nn_read_ren=1; read ctrl vars = (0,y,x).
    - Capture nn_read_data, x, y into the write stage; set write valid=1.
    - If x==OUT_W-1: x←0, y←y+1; otherwise x←x+1.
    - At (x==OUT_W-1, y==OUT_H-1): go to DRAIN.
  - DRAIN: the last captured element is written on the first unstalled cycle; then go to DONE.
  - DONE: done=1 for exactly one cycle; then IDLE.
- Latency and write rules:
  - Read-to-write latency is 1 unstalled cycle.
  - nn_write_wen = write valid & ~stall.
  - The write stage shifts only when stall=0. Write valid clears when no new read is issued.
- Stall:
  - stall=1 forces nn_read_ren=0 and nn_write_wen=0.
  - Counters, FSM state and write registers all hold.
  - Every domain point is read exactly once and written exactly once regardless of stall pattern.
- Timing: unstalled frame from start to done pulse = OUT_W*OUT_H+2 cycles. busy covers RUN and DRAIN.
- Flush:
  - Next state IDLE; x=y=0; write valid=0; no done pulse.
  - Flush overrides stall and start.
  - Flush takes effect in the same cycle for the enables: ren=wen=0 while flush=1.
- Ctrl vars:
  - ctrl_vars[0] is constant 0.
  - Read ctrl vars are 0 outside RUN.
  - Counters are CTRL_W bits and are zero-extended.
- Degenerate case OUT_W=OUT_H=1: RUN lasts one cycle, then DRAIN, then DONE.

Optional Feature:
- Macro: NN_UPSAMPLE_STAGE_PERF_EN.
- When defined:
  - Adds output stall_cycles (32 bits): count of cycles with busy=1 and stall=1.
  - Cleared on reset and on start acceptance; saturates at 2^32-1; holds its value after done.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package up_sample_pkg holds:
  - Default DATA_W and CTRL_W constants.
  - State enum typedef (IDLE/RUN/DRAIN/DONE).
  - Ctrl-vars array typedef (3xCTRL_W).
- One natural sub-module: up_sample_domain_iter, a 2-D wrapping counter with enable/clear and a last flag, reusable by the other stage controllers.

Test Plan:
- Reset, then start with stall=0, W=H=128, upstream model filled with value=row*64+col → done at cycle 16386 after start. Downstream (y,x) holds upstream(floor(y/2),floor(x/2)); e.g. (5,7)→2*64+3=131.
- Randomly toggle stall (~30%) through one frame → exactly 16384 writes, no duplicate or missing coordinates, and wen never asserted while stall=1.
- Assert flush at RUN x=10,y=3 → next cycle state IDLE, busy=0, no done pulse. A following start produces a full correct frame starting from (0,0).
- Deassert rst_n asynchronously mid-frame, between clock edges → outputs drop to 0 immediately. After release, start is required to resume.
- Pulse start while busy at (0,50) → ignored; only one done pulse is produced.
- With NN_UPSAMPLE_STAGE_PERF_EN defined, stall for 37 cycles during a frame → stall_cycles=37 at done.
